// File: rtl/and_chk_pkg.sv
// and_chk_pkg: shared state type and default parameters for the AND response checker
package and_chk_pkg;
    localparam int LATENCY_DEF = 1;
    localparam int CNT_W_DEF   = 16;
    localparam int MAX_ERR_DEF = 8;
    localparam int FILL_W      = 3;
    typedef enum logic [1:0] {IDLE, FILL, CHECK, HALT} state_t;
endpackage

// File: rtl/and_chk_delay.sv
// and_chk_delay: DEPTH-stage 1-bit shift register aligning expected data with the DUT output
module and_chk_delay #(
    parameter int DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [DEPTH-1:0] r_sr;
    // shift one stage per cycle, always running so a re-arm refills from live inputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
        end
    end
    assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/and_response_checker.sv
// and_response_checker: compares a registered-AND DUT output against a delayed reference and counts mismatches
module and_response_checker
    import and_chk_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MAX_ERR = MAX_ERR_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             ain,
    input  logic             bin,
    input  logic             dut_reset,
    input  logic             dut_out,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             error,
    output logic             busy,
    output logic             halted
);
    state_t              r_state;
    logic [FILL_W-1:0]   r_fill;
    logic [CNT_W-1:0]    r_smp;
    logic [CNT_W-1:0]    r_err;
    logic [CNT_W-1:0]    r_first;
    logic                r_error;
    logic                r_busy;
    logic                r_halted;
    logic                w_din;
    logic                w_exp;
    logic                w_mis;
    logic                w_halt;
    logic [CNT_W-1:0]    w_smp_inc;
    logic [CNT_W-1:0]    w_err_inc;

    assign w_din = dut_reset ? 1'b0 : (ain & bin);

    and_chk_delay #(.DEPTH(LATENCY)) u_delay (
        .i_clk  (clock),
        .i_rst_n(reset),
        .i_d    (w_din),
        .o_q    (w_exp)
    );

    // saturating increments and the halt threshold test
    always_comb begin
        w_mis     = dut_out ^ w_exp;
        w_smp_inc = (&r_smp) ? r_smp : r_smp + 1'b1;
        w_err_inc = (&r_err) ? r_err : r_err + 1'b1;
        w_halt    = (w_err_inc == CNT_W'(MAX_ERR));
    end

    // control FSM with counters and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_fill   <= '0;
            r_smp    <= '0;
            r_err    <= '0;
            r_first  <= '0;
            r_error  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state  <= FILL;
                        r_fill   <= '0;
                        r_smp    <= '0;
                        r_err    <= '0;
                        r_first  <= '0;
                        r_error  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                FILL: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_fill == FILL_W'(LATENCY - 1)) begin
                        r_state <= CHECK;
                    end else begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
                CHECK: begin
                    r_smp <= w_smp_inc;
                    if (w_mis) begin
                        r_err   <= w_err_inc;
                        r_error <= 1'b1;
                        if (!r_error) r_first <= r_smp;
                    end
                    if (!enable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_mis && w_halt) begin
                        r_state  <= HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (!enable) begin
                        r_state  <= IDLE;
                        r_halted <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sample_count  = r_smp;
    assign error_count   = r_err;
    assign first_err_idx = r_first;
    assign error         = r_error;
    assign busy          = r_busy;
    assign halted        = r_halted;
endmodule

// File: doc/and_response_checker.md
AND_RESPONSE_CHECKER -- requirements
Module: and_response_checker

Interface
REQ-001 Parameter LATENCY, default 1, is the DUT output latency in clock cycles, with legal range 1..4.
REQ-002 Parameter CNT_W, default 16, is the width of all counters.
REQ-003 Parameter MAX_ERR, default 8, is the error count at which checking halts; its legal range is 1..2^CNT_W-1.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, as listed in REQ-005 and REQ-006.
REQ-005 Port clock, input, 1 bit: the single clock; all logic SHALL act on the rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low (0 = reset).
REQ-007 Port enable, input, 1 bit: when 1, the block arms and checks; when 0, it returns to idle.
REQ-008 Port ain, input, 1 bit: DUT operand A, as driven by the stimulus side.
REQ-009 Port bin, input, 1 bit: DUT operand B.
REQ-010 Port dut_reset, input, 1 bit: the DUT's own reset, active-high; when 1, the expected DUT output is 0.
REQ-011 Port dut_out, input, 1 bit: the registered AND output of the DUT under check.
REQ-012 Port sample_count, output, CNT_W bits: number of compared samples.
REQ-013 Port error_count, output, CNT_W bits: number of mismatches.
REQ-014 Port first_err_idx, output, CNT_W bits: the sample_count value at the first mismatch.
REQ-015 Port error, output, 1 bit: sticky flag set by any mismatch.
REQ-016 Port busy, output, 1 bit: 1 in states FILL and CHECK.
REQ-017 Port halted, output, 1 bit: 1 in state HALT.

Function
REQ-018 The expected value entering the delay line each cycle SHALL be (dut_reset ? 0 : ain & bin).
REQ-019 The expected value SHALL pass through exactly LATENCY register stages before it is compared with dut_out.
REQ-020 The FSM states SHALL be IDLE, FILL, CHECK and HALT.
REQ-021 In IDLE with enable=1, the FSM SHALL go to FILL on the next edge, and that same edge SHALL clear all counters, first_err_idx and error.
REQ-022 FILL SHALL last exactly LATENCY cycles with no comparisons, then go to CHECK.
REQ-023 In CHECK, each cycle SHALL increment sample_count by 1.
REQ-024 In CHECK, on dut_out != expected, error_count SHALL increment by 1 and error SHALL be set.
REQ-025 On the first mismatch, first_err_idx SHALL capture the pre-increment value of sample_count.
REQ-026 Counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-027 When error_count reaches MAX_ERR, the FSM SHALL go to HALT, where counters freeze.
REQ-028 enable=0 in FILL, CHECK or HALT SHALL return the FSM to IDLE on the next edge, with all counters and flags held, not cleared.
REQ-029 If enable falls in a cycle with a mismatch in CHECK, that mismatch SHALL still be counted.
REQ-030 The delay line SHALL keep shifting in all states, so a re-arm refills it from live inputs.
REQ-031 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-032 reset=0 SHALL asynchronously force state IDLE, clear all counters, first_err_idx, error, busy and halted, and clear the delay line.
REQ-033 Reset mid-CHECK SHALL abort checking; after release, the block SHALL stay in IDLE until enable=1 is sampled.

Structure
REQ-034 Package and_chk_pkg SHALL hold the state typedef (IDLE/FILL/CHECK/HALT) and the default LATENCY, CNT_W and MAX_ERR constants.
REQ-035 Sub-module and_chk_delay SHALL implement the parameterised LATENCY-deep 1-bit shift register with async active-low reset.

Verification
REQ-036 Correct DUT, LATENCY=1, enable=1 for 20 cycles of mixed ain/bin -> sample_count=19, error_count=0, error=0.
REQ-037 Inject a dut_out flip on the 5th compared sample -> error=1, error_count=1, first_err_idx=4.
REQ-038 dut_out stuck at 1 with ain=bin=0 and MAX_ERR=8 -> halted=1 after 8 compared samples, with counters frozen at 8.
REQ-039 dut_reset=1 with ain=bin=1 and dut_out=0 -> no errors are counted.
REQ-040 reset=0 pulse mid-CHECK -> all outputs read 0 immediately, and busy=0 until enable is re-sampled.
REQ-041 LATENCY=3 with a correct DUT model -> FILL lasts 3 cycles, then there are zero errors over 16 samples.
